// File: rtl/core_clk_ctrl.sv
// core_clk_ctrl: single-domain clk_en strobe generator with HALT/RUN/STEP modes and a debounced step button.
// Define CORE_CLK_CYC_CNT_EN to build the cyc_cnt strobe counter; otherwise cyc_cnt is tied to 0.
module core_clk_ctrl #(
    parameter int DIV_W   = 8,
    parameter int DEB_CYC = 50000,
    parameter int CNT_W   = 32
) (
    input  logic             fastclk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    output logic             clk_en,
    output logic             running,
    output logic [CNT_W-1:0] cyc_cnt
);
    localparam int DEB_W = $clog2(DEB_CYC + 1);

    typedef enum logic [1:0] {HALT, RUN, STEP_IDLE, STEP_FIRE} state_t;

    state_t           state_q, state_d, follow;
    logic             sync1_q, sync2_q;
    logic             btn_lvl_q, btn_lvl_d, deb_hit, step_pulse, wrap;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d, ratio_q, ratio_d;
    logic             clk_en_q, clk_en_d, running_q;

    always_comb begin
        deb_hit    = (sync2_q != btn_lvl_q) && (deb_cnt_q == DEB_W'(DEB_CYC - 1));
        btn_lvl_d  = btn_lvl_q ^ deb_hit;
        deb_cnt_d  = (sync2_q == btn_lvl_q || deb_hit) ? '0 : deb_cnt_q + DEB_W'(1);
        step_pulse = deb_hit && !btn_lvl_q;
    end

    // every state except STEP_IDLE simply follows mode; STEP_IDLE alone reacts to the button
    always_comb begin
        follow    = (mode == 2'b01) ? RUN : (mode == 2'b10) ? STEP_IDLE : HALT;
        state_d   = (state_q == STEP_IDLE && step_pulse) ? STEP_FIRE : follow;
        wrap      = (state_q == RUN) && (div_cnt_q == ratio_q);
        clk_en_d  = (state_q == STEP_IDLE && step_pulse) || (wrap && state_d == RUN);
        div_cnt_d = (state_q == RUN && state_d == RUN && !wrap) ? div_cnt_q + DIV_W'(1) : '0;
        ratio_d   = (state_d == RUN && (state_q != RUN || wrap)) ? div_ratio : ratio_q;
    end

    always_ff @(posedge fastclk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            btn_lvl_q <= 1'b0;
            deb_cnt_q <= '0;
            state_q   <= HALT;
            div_cnt_q <= '0;
            ratio_q   <= '0;
            clk_en_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            sync1_q   <= step_btn;
            sync2_q   <= sync1_q;
            btn_lvl_q <= btn_lvl_d;
            deb_cnt_q <= deb_cnt_d;
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            ratio_q   <= ratio_d;
            clk_en_q  <= clk_en_d;
            running_q <= (state_d == RUN);
        end
    end

    assign clk_en  = clk_en_q;
    assign running = running_q;

`ifdef CORE_CLK_CYC_CNT_EN
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;

    always_comb cyc_cnt_d = cyc_cnt_q + CNT_W'(clk_en_d);

    always_ff @(posedge fastclk) begin
        if (reset) cyc_cnt_q <= '0;
        else cyc_cnt_q <= cyc_cnt_d;
    end

    assign cyc_cnt = cyc_cnt_q;
`else
    assign cyc_cnt = '0;
`endif
endmodule
